// File: rtl/mem_arbiter.sv
// Byte-wide RAM arbiter that serves icache block refills and load/store requests.
// Define MEM_ARBITER_RR_EN for round-robin arbitration; otherwise load/store has fixed priority.
module mem_arbiter #(
    parameter int ADDR_WIDTH  = 17,
    parameter int BLOCK_WIDTH = 4
) (
    input  logic                              clkIn,
    input  logic                              resetIn,
    input  logic                              rdyIn,
    input  logic [7:0]                        ramDataIn,
    output logic [7:0]                        ramDataOut,
    output logic [ADDR_WIDTH-1:0]             ramAddr,
    output logic                              ramWr,
    input  logic                              icacheMiss,
    input  logic [ADDR_WIDTH-BLOCK_WIDTH-1:0] icacheAddr,
    output logic                              icacheDataValid,
    output logic [ADDR_WIDTH-BLOCK_WIDTH-1:0] icacheAddrOut,
    output logic [(2**BLOCK_WIDTH)*8-1:0]     icacheData,
    input  logic                              lsValid,
    input  logic                              lsWrite,
    input  logic [ADDR_WIDTH-1:0]             lsAddr,
    input  logic [1:0]                        lsSize,
    input  logic [31:0]                       lsDataIn,
    output logic                              lsDone,
    output logic [31:0]                       lsDataOut
);

    localparam int BLOCK_SIZE = 2**BLOCK_WIDTH;
    localparam int CW         = (BLOCK_WIDTH + 1 > 3) ? BLOCK_WIDTH + 1 : 3;

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, STORE, DONE} state_t;

    state_t                  r_state, w_next;
    logic [CW-1:0]           r_k, r_n, w_byte;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [31:0]             r_wdata, r_ldata, w_ld_merged;
    logic [BLOCK_SIZE*8-1:0] r_fill, w_fill_merged;
    logic                    r_src_ls;
    logic                    w_grant_ls, w_grant_ic;
    logic [CW-1:0]           w_req_n;

`ifdef MEM_ARBITER_RR_EN
    logic r_last_ls;
    assign w_grant_ls = lsValid && (!icacheMiss || !r_last_ls);
`else
    assign w_grant_ls = lsValid;
`endif
    assign w_grant_ic = icacheMiss && !w_grant_ls;

    always_comb begin
        case (lsSize)
            2'b00:   w_req_n = CW'(1);
            2'b01:   w_req_n = CW'(2);
            default: w_req_n = CW'(4);
        endcase
    end

    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) r_state <= IDLE;
        else if (rdyIn) r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_ls)      w_next = lsWrite ? STORE : LOAD;
                else if (w_grant_ic) w_next = FETCH;
            end
            FETCH, LOAD: if (r_k == r_n) w_next = DONE;
            STORE:       if (r_k == r_n - CW'(1)) w_next = DONE;
            DONE:        w_next = IDLE;
            default:     w_next = IDLE;
        endcase
    end

    // Reads capture byte k-1 in the cycle that issues address k (1-cycle RAM latency).
    always_comb begin
        w_byte        = r_k - CW'(1);
        w_fill_merged = r_fill;
        w_ld_merged   = r_ldata;
        if (r_state == FETCH && r_k != '0)
            w_fill_merged[{w_byte[BLOCK_WIDTH-1:0], 3'b000} +: 8] = ramDataIn;
        if (r_state == LOAD && r_k != '0)
            w_ld_merged[{w_byte[1:0], 3'b000} +: 8] = ramDataIn;
    end

    always_ff @(posedge clkIn or negedge resetIn) begin
        if (!resetIn) begin
            r_k           <= '0;
            r_n           <= '0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_ldata       <= '0;
            r_fill        <= '0;
            r_src_ls      <= 1'b0;
            icacheData    <= '0;
            icacheAddrOut <= '0;
            lsDataOut     <= '0;
`ifdef MEM_ARBITER_RR_EN
            r_last_ls     <= 1'b0;
`endif
        end else if (rdyIn) begin
            case (r_state)
                IDLE: begin
                    r_k <= '0;
                    if (w_grant_ls) begin
                        r_addr   <= lsAddr;
                        r_wdata  <= lsDataIn;
                        r_n      <= w_req_n;
                        r_ldata  <= '0;
                        r_src_ls <= 1'b1;
`ifdef MEM_ARBITER_RR_EN
                        r_last_ls <= 1'b1;
`endif
                    end else if (w_grant_ic) begin
                        r_addr   <= {icacheAddr, {BLOCK_WIDTH{1'b0}}};
                        r_n      <= CW'(BLOCK_SIZE);
                        r_src_ls <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
                        r_last_ls <= 1'b0;
`endif
                    end
                end
                FETCH: begin
                    r_k    <= r_k + CW'(1);
                    r_fill <= w_fill_merged;
                    if (r_k == r_n) begin
                        icacheData    <= w_fill_merged;
                        icacheAddrOut <= r_addr[ADDR_WIDTH-1:BLOCK_WIDTH];
                    end
                end
                LOAD: begin
                    r_k     <= r_k + CW'(1);
                    r_ldata <= w_ld_merged;
                    if (r_k == r_n) lsDataOut <= w_ld_merged;
                end
                STORE:   r_k <= r_k + CW'(1);
                default: r_k <= '0;
            endcase
        end
    end

    always_comb begin
        ramWr           = 1'b0;
        ramAddr         = '0;
        ramDataOut      = '0;
        icacheDataValid = 1'b0;
        lsDone          = 1'b0;
        case (r_state)
            FETCH, LOAD: begin
                if (r_k != r_n) ramAddr = r_addr + ADDR_WIDTH'(r_k);
            end
            STORE: begin
                ramWr      = rdyIn;
                ramAddr    = r_addr + ADDR_WIDTH'(r_k);
                ramDataOut = r_wdata[{r_k[1:0], 3'b000} +: 8];
            end
            DONE: begin
                icacheDataValid = rdyIn && !r_src_ls;
                lsDone          = rdyIn && r_src_ls;
            end
            default: ;
        endcase
    end

endmodule
